// File: rtl/mem_access_ctrl.sv
// Load/store access controller between the core and a word-only memory; sub-word stores use RMW.
// Optional misalignment checking is enabled by defining MEM_ACCESS_ALIGN_CHECK_EN.
module mem_access_ctrl #(
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic        mem_we,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_t;

  state_t      state;
  logic [1:0]  lane_q;
  logic [1:0]  size_q;
  logic        we_q;
  logic        signed_q;
  logic [31:0] wdata_q;

  logic        range_err;
  logic        size_err;
  logic        align_err;
  logic        req_err;
  logic [1:0]  req_lane;
  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [31:0] mask;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  always_comb begin
    range_err = {2'b00, req_addr[31:2]} >= 32'(MEM_WORDS);
    size_err  = (req_size == 2'b11);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    align_err = ((req_size == 2'b01) && req_addr[0]) ||
                ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    align_err = 1'b0;
`endif
    req_err = range_err || size_err || align_err;
    // Low address bits are forced aligned for half/word accesses.
    case (req_size)
      2'b00:   req_lane = req_addr[1:0];
      2'b01:   req_lane = {req_addr[1], 1'b0};
      default: req_lane = 2'b00;
    endcase
  end

  always_comb begin
    shamt   = {lane_q, 3'b000};
    shifted = mem_read_data >> shamt;
    case (size_q)
      2'b00:   load_data = signed_q ? {{24{shifted[7]}}, shifted[7:0]}
                                    : {24'h000000, shifted[7:0]};
      2'b01:   load_data = signed_q ? {{16{shifted[15]}}, shifted[15:0]}
                                    : {16'h0000, shifted[15:0]};
      default: load_data = mem_read_data;
    endcase
    mask       = (size_q == 2'b00) ? 32'h0000_00ff : 32'h0000_ffff;
    merge_data = (mem_read_data & ~(mask << shamt)) | ((wdata_q & mask) << shamt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= StIdle;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_rdata     <= 32'h0;
      resp_err       <= 1'b0;
      mem_we         <= 1'b0;
      mem_address    <= 32'h0;
      mem_write_data <= 32'h0;
      lane_q         <= 2'b00;
      size_q         <= 2'b00;
      we_q           <= 1'b0;
      signed_q       <= 1'b0;
      wdata_q        <= 32'h0;
    end else begin
      case (state)
        StIdle: begin
          if (req_valid && req_ready) begin
            lane_q    <= req_lane;
            size_q    <= req_size;
            we_q      <= req_we;
            signed_q  <= req_signed;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            resp_rdata <= 32'h0;
            if (req_err) begin
              state      <= StResp;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              resp_err    <= 1'b0;
              mem_address <= {2'b00, req_addr[31:2]};
              if (req_we && (req_size == 2'b10)) begin
                state          <= StWr;
                mem_we         <= 1'b1;
                mem_write_data <= req_wdata;
              end else begin
                state <= StRd;
              end
            end
          end
        end
        StRd: begin
          if (we_q) begin
            state          <= StWr;
            mem_we         <= 1'b1;
            mem_write_data <= merge_data;
          end else begin
            state      <= StResp;
            resp_valid <= 1'b1;
            resp_rdata <= load_data;
          end
        end
        StWr: begin
          mem_we     <= 1'b0;
          state      <= StResp;
          resp_valid <= 1'b1;
        end
        StResp: begin
          if (resp_ready) begin
            state      <= StIdle;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
